// File: rtl/console_out_arb_if.sv
`default_nettype none
// ============================================================================
// console_out_arb_if : requester, console sink and status signals of the
//                      console output arbiter
// Revision 1.0
// ============================================================================
interface console_out_arb_if;
  logic [7:0] REQ0_DATA;
  logic       REQ0_valid;
  logic       REQ0_ready;
  logic [7:0] REQ1_DATA;
  logic       REQ1_valid;
  logic       REQ1_ready;
  logic [7:0] CONSOLE_OUT;
  logic       CONSOLE_OUT_valid;
  logic       CONSOLE_OUT_ready;
  logic [4:0] FIFO_COUNT;
  logic [1:0] OWNER;

  modport master (
    output REQ0_DATA, REQ0_valid, REQ1_DATA, REQ1_valid, CONSOLE_OUT_ready,
    input  REQ0_ready, REQ1_ready, CONSOLE_OUT, CONSOLE_OUT_valid,
           FIFO_COUNT, OWNER
  );

  modport slave (
    input  REQ0_DATA, REQ0_valid, REQ1_DATA, REQ1_valid, CONSOLE_OUT_ready,
    output REQ0_ready, REQ1_ready, CONSOLE_OUT, CONSOLE_OUT_valid,
           FIFO_COUNT, OWNER
  );
endinterface
`default_nettype wire

// File: rtl/console_out_arb.sv
`default_nettype none
// ============================================================================
// console_out_arb : two-requester line-locked arbiter feeding a console FIFO
// Revision 1.0
// ============================================================================
module console_out_arb #(
  parameter int         DEPTH   = 8,
  parameter int         TIMEOUT = 255,
  parameter logic [7:0] EOL     = 8'h0A
) (
  input  logic              CLK,
  input  logic              RESET,
  console_out_arb_if.slave  bus
);
  localparam int         c_aw       = $clog2(DEPTH);
  localparam logic [4:0] c_depth    = 5'(DEPTH);
  localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);
  localparam logic [c_aw-1:0] c_ptr_one = c_aw'(1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  state_t          state_q, state_d;
  logic            last_grant_q, last_grant_d;
  logic [7:0]      idle_cnt_q, idle_cnt_d;
  logic [c_aw-1:0] wptr_q, rptr_q;
  logic [4:0]      count_q;
  logic [7:0]      mem_q [DEPTH];

  logic       w_full, w_win1, w_rdy0, w_rdy1;
  logic       w_push0, w_push1, w_push, w_pop, w_eol;
  logic [7:0] w_wdata;

  // On a tie the requester that did not transfer last wins; last_grant_q=1 favours requester 0.
  assign w_full  = (count_q == c_depth);
  assign w_win1  = bus.REQ1_valid && (!bus.REQ0_valid || !last_grant_q);
  assign w_rdy0  = !w_full && ((state_q == OWN0) || ((state_q == IDLE) && !w_win1));
  assign w_rdy1  = !w_full && ((state_q == OWN1) || ((state_q == IDLE) && w_win1));
  assign w_push0 = bus.REQ0_valid && w_rdy0;
  assign w_push1 = bus.REQ1_valid && w_rdy1;
  assign w_push  = w_push0 || w_push1;
  assign w_wdata = w_push1 ? bus.REQ1_DATA : bus.REQ0_DATA;
  assign w_eol   = (w_wdata == EOL);
  assign w_pop   = (count_q != 5'd0) && bus.CONSOLE_OUT_ready;

  assign bus.REQ0_ready        = w_rdy0;
  assign bus.REQ1_ready        = w_rdy1;
  assign bus.CONSOLE_OUT       = mem_q[rptr_q];
  assign bus.CONSOLE_OUT_valid = (count_q != 5'd0);
  assign bus.FIFO_COUNT        = count_q;
  assign bus.OWNER             = state_q;

  always_comb begin
    state_d      = state_q;
    idle_cnt_d   = idle_cnt_q;
    last_grant_d = last_grant_q;
    if (w_push0)      last_grant_d = 1'b0;
    else if (w_push1) last_grant_d = 1'b1;
    case (state_q)
      IDLE: begin
        idle_cnt_d = 8'd0;
        if (w_push0 && !w_eol)      state_d = OWN0;
        else if (w_push1 && !w_eol) state_d = OWN1;
      end
      OWN0: begin
        if (bus.REQ0_valid) begin
          idle_cnt_d = 8'd0;
          if (w_push0 && w_eol) state_d = IDLE;
        end else if (idle_cnt_q == c_tmo_last) begin
          state_d    = IDLE;
          idle_cnt_d = 8'd0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      OWN1: begin
        if (bus.REQ1_valid) begin
          idle_cnt_d = 8'd0;
          if (w_push1 && w_eol) state_d = IDLE;
        end else if (idle_cnt_q == c_tmo_last) begin
          state_d    = IDLE;
          idle_cnt_d = 8'd0;
        end else begin
          idle_cnt_d = idle_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        idle_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      idle_cnt_q   <= 8'd0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= 5'd0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      idle_cnt_q   <= idle_cnt_d;
      if (w_push) wptr_q <= wptr_q + c_ptr_one;
      if (w_pop)  rptr_q <= rptr_q + c_ptr_one;
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 5'd1;
        2'b01:   count_q <= count_q - 5'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: a write during reset is harmless once the pointers clear.
  always_ff @(posedge CLK) begin
    if (w_push) mem_q[wptr_q] <= w_wdata;
  end
endmodule
`default_nettype wire

// File: doc/console_out_arb.md
CONSOLE_OUT_ARB -- requirements
Module: console_out_arb

Interface
REQ-001 The block SHALL have one clock, CLK; RESET SHALL be synchronous and active-high.
REQ-002 Parameter DEPTH, 8, FIFO entries (power of 2, 2..16).
REQ-003 Parameter TIMEOUT, 255, consecutive owner-idle cycles before forced release (1..255).
REQ-004 Parameter EOL, 8'h0A, byte value that ends a line and releases ownership.
REQ-005 CLK  input  1  rising-edge clock.
REQ-006 RESET  input  1  synchronous active-high reset.
REQ-007 REQ0_DATA  input  8  byte from requester 0 (processor console path).
REQ-008 REQ0_valid  input  1  requester 0 byte available.
REQ-009 REQ0_ready  output  1  block accepts REQ0_DATA this cycle.
REQ-010 REQ1_DATA  input  8  byte from requester 1 (debug/monitor).
REQ-011 REQ1_valid  input  1  requester 1 byte available.
REQ-012 REQ1_ready  output  1  block accepts REQ1_DATA this cycle.
REQ-013 CONSOLE_OUT  output  8  byte at FIFO head.
REQ-014 CONSOLE_OUT_valid  output  1  FIFO non-empty.
REQ-015 CONSOLE_OUT_ready  input  1  console sink takes the head byte.
REQ-016 FIFO_COUNT  output  5  current FIFO occupancy, 0..DEPTH.
REQ-017 OWNER  output  2  00 idle, 01 requester 0, 10 requester 1; 11 never driven.

Function
REQ-018 Transfer on any port SHALL occur only in a cycle where valid and ready are both 1; at most one requester transfers per cycle.
REQ-019 FSM states SHALL be IDLE, OWN0 and OWN1; OWNER reflects the registered state.
REQ-020 REQx_ready SHALL be combinational: FIFO not full AND (state==OWNx OR (state==IDLE AND x is the IDLE winner)); ready SHALL NOT depend on same-cycle CONSOLE_OUT pop.
REQ-021 IDLE winner: the only valid requester; if both valid, the requester not in last_grant; last_grant SHALL update to x on every requester-x transfer.
REQ-022 IDLE -> OWNx on requester-x transfer of a non-EOL byte; transfer of EOL in IDLE SHALL leave state IDLE.
REQ-023 OWNx -> IDLE on requester-x transfer of an EOL byte; the EOL byte SHALL be written to the FIFO.
REQ-024 In OWNx the other requester's ready SHALL be 0 regardless of FIFO space.
REQ-025 Idle counter (8 bit): cleared on entry to OWNx and in any OWNx cycle with REQx_valid=1 (including stalled by full FIFO); incremented in OWNx cycles with REQx_valid=0; when it equals TIMEOUT-1 in such a cycle, state SHALL become IDLE and counter 0 at the next edge.
REQ-026 FIFO: circular, write and read pointers wrap modulo DEPTH; full when FIFO_COUNT==DEPTH, empty when 0.
REQ-027 CONSOLE_OUT_valid SHALL be 1 exactly when FIFO_COUNT != 0; CONSOLE_OUT SHALL show the head byte and hold stable while valid=1 and ready=0.
REQ-028 Pop SHALL occur when CONSOLE_OUT_valid and CONSOLE_OUT_ready are both 1; simultaneous push and pop SHALL leave FIFO_COUNT unchanged.
REQ-029 Latency: byte accepted at edge N into an empty FIFO SHALL appear on CONSOLE_OUT with valid=1 in the cycle after edge N.
REQ-030 Bytes SHALL leave in acceptance order; no byte SHALL be dropped or duplicated.

Reset
REQ-031 At a RESET edge: FIFO pointers and FIFO_COUNT 0, state IDLE (OWNER=00), last_grant=1 (requester 0 wins first tie), idle counter 0.
REQ-032 After reset CONSOLE_OUT_valid=0, REQx_ready per REQ-020 (REQ0_ready=1 if REQ0_valid=1); CONSOLE_OUT value is don't-care while valid=0.
REQ-033 RESET asserted mid-operation SHALL discard FIFO contents and ownership; RESET SHALL take priority over any same-cycle transfer.

Verification
REQ-034 Tie: after reset both valid, REQ0 "A" (0x41), REQ1 "B" (0x42) -> REQ0 accepted first, OWNER=01, REQ1_ready=0; CONSOLE_OUT=0x41 one cycle later.
REQ-035 Line lock: REQ0 sends 0x48,0x69,0x0A while REQ1 valid -> output 0x48,0x69,0x0A then REQ1 byte; OWNER 01 -> 00 -> 10.
REQ-036 Full: CONSOLE_OUT_ready=0, REQ0 streams 10 bytes with no EOL -> 8 accepted, FIFO_COUNT=8, REQ0_ready=0; raise ready -> 8 bytes in order, count returns to 0, pointers wrap correctly on refill.
REQ-037 Timeout (TIMEOUT=4): REQ0 sends 0x31 then valid=0 for 4 cycles -> OWNER=00 after 4th idle edge; REQ1 then granted; 3 idle cycles then REQ0 valid -> no release.
REQ-038 Reset mid-stream: FIFO_COUNT=5, OWNER=10, assert RESET one cycle -> FIFO_COUNT=0, CONSOLE_OUT_valid=0, OWNER=00; next tie goes to REQ0.
